ex_share_arbiter: RTL
=====================

# ex_share_arbiter

Round-robin arbiter and sequencer sharing one `ExEntity`-style add/subtract datapath among `NREQ` requesters. Each requester offers an operand pair, `A` and `B`, with a valid/ready handshake. The winner's pair is computed as `A + B - DELTA` and registered into a one-entry result slot, tagged with the winner's index. The block sits between the requester clients and a single downstream consumer that applies backpressure.

## Interface
- `NREQ`, default 4: number of requesters (2..16).
- `NBITS`, default 8: operand and result width.
- `DELTA`, default 16: constant subtracted, as in the shared datapath.
- `CLK` input, 1 bit: the single clock.
- `RST` input, 1 bit: reset, synchronous, active-high. This is already decided.
- `REQ_VALID` input, `NREQ` bits: requester `i` offers an operand pair.
- `REQ_A` input, `NREQ*NBITS` bits: packed operand `A`; requester `i` occupies bits `[i*NBITS +: NBITS]`.
- `REQ_B` input, `NREQ*NBITS` bits: packed operand `B`, same packing as `REQ_A`.
- `REQ_READY` output, `NREQ` bits: one-hot grant; the pair is accepted this cycle.
- `RES_VALID` output, 1 bit: the result slot is full.
- `RES_DATA` output, `NBITS` bits: the registered result.
- `RES_ID` output, `IDW = $clog2(NREQ)` bits: index of the requester that produced the result.
- `RES_READY` input, 1 bit: the consumer takes the result this cycle.

## Operation
- Slot FSM states:
  - `EMPTY`: `RES_VALID` = 0.
  - `FULL`: `RES_VALID` = 1.
- Accept condition: `can_accept` = (state == `EMPTY`) || `RES_READY`.
- Grant:
  - When `can_accept` = 1 and any `REQ_VALID` is high, grant exactly one requester.
  - The winner is the first valid requester scanning from `LAST+1` modulo `NREQ`, upward with wrap.
  - `REQ_READY` is the one-hot of the winner; it is all-zero otherwise.
  - `REQ_READY[i]` is never high unless `REQ_VALID[i]` is high.
- Requester rule: once `REQ_VALID[i]` is raised, `REQ_VALID[i]` and the operand data stay stable until `REQ_READY[i]` is seen. The block's correctness does not depend on this rule; it only affects which pair is captured.
- On a grant:
  - `RES_DATA` <= `A + B - DELTA`, evaluated in the shared datapath.
  - `RES_ID` <= winner index.
  - `LAST` <= winner index.
  - State <= `FULL`.
- Transitions:
  - `EMPTY` to `FULL` on a grant.
  - `FULL` to `EMPTY` when `RES_READY` = 1 and there is no grant.
  - `FULL` stays `FULL` when `RES_READY` = 1 and there is a grant; this is a back-to-back replace.
  - `FULL` stays `FULL` with data held when `RES_READY` = 0.
- Arithmetic, default build: the result is modulo 2^`NBITS`; both carry and borrow are discarded.
- `LAST` is not updated when there is no grant.

## Timing
- Latency: a grant in cycle N gives `RES_VALID` = 1 with the result in cycle N+1.
- Throughput: one result per cycle when `RES_READY` is held high.
- `REQ_READY` is combinational from `REQ_VALID`, `RES_READY`, state and `LAST`. There is no combinational path from any data input to any output.
- Outputs `RES_VALID`, `RES_DATA` and `RES_ID` are registered.
- Reset values:
  - State = `EMPTY`.
  - `RES_VALID` = 0.
  - `RES_DATA` = 0.
  - `RES_ID` = 0.
  - `LAST` = `NREQ-1`, so requester 0 has top priority first.
  - `REQ_READY` = 0 while `RST` is high.
- Reset during operation: any pending result is discarded, and `RES_VALID` is 0 in the cycle after `RST`. Requests presented while `RST` is high are not granted.
- Simultaneous drain and grant: the new result replaces the drained one. `RES_VALID` stays 1 with no bubble.

## Configuration
- Macro `EX_SHARE_ARB_SATURATE_EN`.
- When defined:
  - The sum is computed at `NBITS+2` bits, signed.
  - A result below 0 clamps to 0.
  - A result above 2^`NBITS`-1 clamps to 2^`NBITS`-1.
  - An extra registered output, `RES_SAT` (1 bit), is set when clamping occurred. `RES_SAT` resets to 0.
- When undefined: the result wraps, and there is no `RES_SAT` port.

## Structure
- Package `ex_share_pkg`:
  - Slot state enum (`EMPTY`, `FULL`).
  - A function returning `IDW` for a given `NREQ`.
  - Round-robin priority-select function: takes the valid mask and `LAST`, returns a one-hot grant.
- Sub-module `ex_addsub`:
  - Combinational `NBITS`/`DELTA` datapath computing `A + B - DELTA`.
  - Includes the clamp logic under the macro.
  - Instantiated once, fed by a mux selected by the winner index.

## Test plan
- Single request: `REQ_VALID` = 0001, `A` = 20, `B` = 5 -> `REQ_READY` = 0001 in the same cycle; next cycle `RES_VALID` = 1, `RES_DATA` = 9, `RES_ID` = 0.
- Wrap, macro off: `A` = 3, `B` = 4 -> `RES_DATA` = 247. `A` = 200, `B` = 100 -> `RES_DATA` = 28.
- Saturate, macro on: the same two cases -> `RES_DATA` = 0 with `RES_SAT` = 1, then `RES_DATA` = 255 with `RES_SAT` = 1. `A` = 20, `B` = 5 -> 9 with `RES_SAT` = 0.
- Fairness: `REQ_VALID` = 1111 held, `RES_READY` = 1 -> grants 0, 1, 2, 3, 0 on consecutive cycles, with `RES_ID` following one cycle later and no bubbles.
- Backpressure:
  - `RES_READY` = 0 with a result held -> `REQ_READY` = 0000, and `RES_DATA`/`RES_ID` stay stable for 5 cycles.
  - Raising `RES_READY` -> drain and next grant in the same cycle.
- Reset mid-stream: `RST` high for 1 cycle while `FULL` -> `RES_VALID` = 0 on the next cycle. The first grant after reset goes to requester 0 even when `REQ_VALID` = 1111.

Source files
------------

// File: rtl/ex_share_pkg.sv
// Shared types and helpers for the round-robin shared add/subtract arbiter.
// Width-generic helpers operate on a 16-requester maximum and are narrowed by the caller.
package ex_share_pkg;

    localparam int MAX_REQ = 16;
    localparam int MAX_IDW = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    function automatic int calc_idw(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // First valid requester scanning upward from last+1, wrapping at nreq.
    function automatic logic [MAX_REQ-1:0] rr_select(
        input logic [MAX_REQ-1:0] valid,
        input logic [MAX_IDW-1:0] last,
        input int                 nreq
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [MAX_IDW-1:0] idx;
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = MAX_IDW'((int'(last) + i) % nreq);
            if (i <= nreq && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/ex_addsub.sv
// Shared combinational datapath: res = a + b - DELTA.
// EX_SHARE_ARB_SATURATE_EN selects clamping to [0, 2^NBITS-1] with a sat flag; otherwise wraps.
module ex_addsub #(
    parameter int NBITS = 8,
    parameter int DELTA = 16
) (
    input  logic [NBITS-1:0] a_i,
    input  logic [NBITS-1:0] b_i,
`ifdef EX_SHARE_ARB_SATURATE_EN
    output logic             sat_o,
`endif
    output logic [NBITS-1:0] res_o
);

`ifdef EX_SHARE_ARB_SATURATE_EN
    localparam logic signed [NBITS+1:0] DELTA_S = (NBITS+2)'(DELTA);
    localparam logic signed [NBITS+1:0] MAX_S   = (NBITS+2)'((1 << NBITS) - 1);

    logic signed [NBITS+1:0] sum_s;

    always_comb begin
        sum_s = $signed({2'b00, a_i}) + $signed({2'b00, b_i}) - DELTA_S;
        sat_o = 1'b0;
        res_o = sum_s[NBITS-1:0];
        if (sum_s < 0) begin
            sat_o = 1'b1;
            res_o = '0;
        end else if (sum_s > MAX_S) begin
            sat_o = 1'b1;
            res_o = '1;
        end
    end
`else
    always_comb begin
        res_o = a_i + b_i - NBITS'(DELTA);
    end
`endif

endmodule

// File: rtl/ex_share_arbiter.sv
// Round-robin arbiter feeding one shared add/subtract datapath into a one-entry result slot.
// Optional clamping and RES_SAT output are enabled with EX_SHARE_ARB_SATURATE_EN.
module ex_share_arbiter
    import ex_share_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int NBITS = 8,
    parameter  int DELTA = 16,
    localparam int IDW   = calc_idw(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ_VALID,
    input  logic [NREQ*NBITS-1:0] REQ_A,
    input  logic [NREQ*NBITS-1:0] REQ_B,
    output logic [NREQ-1:0]       REQ_READY,
    output logic                  RES_VALID,
    output logic [NBITS-1:0]      RES_DATA,
    output logic [IDW-1:0]        RES_ID,
`ifdef EX_SHARE_ARB_SATURATE_EN
    output logic                  RES_SAT,
`endif
    input  logic                  RES_READY
);

    slot_state_e          state_q, state_d;
    logic [NBITS-1:0]     data_q;
    logic [IDW-1:0]       id_q;
    logic [IDW-1:0]       last_q;

    logic                 can_accept;
    logic [MAX_REQ-1:0]   valid_ext;
    logic [MAX_IDW-1:0]   last_ext;
    logic [MAX_REQ-1:0]   grant_full;
    logic [NREQ-1:0]      grant;
    logic                 any_grant;
    logic [IDW-1:0]       win_idx;

    logic [NBITS-1:0]     a_arr [NREQ];
    logic [NBITS-1:0]     b_arr [NREQ];
    logic [NBITS-1:0]     a_sel, b_sel, sum_res;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = REQ_A[gi*NBITS +: NBITS];
            assign b_arr[gi] = REQ_B[gi*NBITS +: NBITS];
        end
    endgenerate

    always_comb begin
        valid_ext              = '0;
        valid_ext[NREQ-1:0]    = REQ_VALID;
        last_ext               = '0;
        last_ext[IDW-1:0]      = last_q;
        can_accept             = (state_q == EMPTY) || RES_READY;
        grant_full             = rr_select(valid_ext, last_ext, NREQ);
        // Nothing is granted while in reset, so LAST keeps its reset value.
        any_grant              = can_accept && !RST && (|grant_full);
        grant                  = any_grant ? grant_full[NREQ-1:0] : '0;
    end

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx = IDW'(i);
            end
        end
    end

    assign a_sel = a_arr[win_idx];
    assign b_sel = b_arr[win_idx];

`ifdef EX_SHARE_ARB_SATURATE_EN
    logic sat_res;
    logic sat_q;

    ex_addsub #(.NBITS(NBITS), .DELTA(DELTA)) u_addsub (
        .a_i   (a_sel),
        .b_i   (b_sel),
        .sat_o (sat_res),
        .res_o (sum_res)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            sat_q <= 1'b0;
        end else if (any_grant) begin
            sat_q <= sat_res;
        end
    end

    assign RES_SAT = sat_q;
`else
    ex_addsub #(.NBITS(NBITS), .DELTA(DELTA)) u_addsub (
        .a_i   (a_sel),
        .b_i   (b_sel),
        .res_o (sum_res)
    );
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (any_grant) state_d = FULL;
            FULL:    if (RES_READY && !any_grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            last_q  <= IDW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            if (any_grant) begin
                data_q <= sum_res;
                id_q   <= win_idx;
                last_q <= win_idx;
            end
        end
    end

    assign REQ_READY = grant;
    assign RES_VALID = (state_q == FULL);
    assign RES_DATA  = data_q;
    assign RES_ID    = id_q;

endmodule
